// File: rtl/dt_skeleton_extract.sv
// Medial-axis extraction over a distance map: flags 4-neighbour local maxima,
// packs the flags MSB-first into 16-bit skeleton words, and tracks max distance and flag count.
module dt_skeleton_extract #(
    parameter int ROW_BITS = 7,
    parameter int COL_BITS = 7,
    parameter int DW       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_i,
    output logic                         res_rd_o,
    output logic [ROW_BITS+COL_BITS-1:0] res_addr_o,
    input  logic [DW-1:0]                res_di_i,
    output logic                         sk_wr_o,
    output logic [ROW_BITS+COL_BITS-5:0] sk_addr_o,
    output logic [15:0]                  sk_do_o,
    output logic [DW-1:0]                max_dist_o,
    output logic [ROW_BITS+COL_BITS:0]   sk_count_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int AW = ROW_BITS + COL_BITS;
    localparam logic [ROW_BITS-1:0] ROW_MAX  = '1;
    localparam logic [COL_BITS-1:0] COL_MAX  = '1;
    localparam logic [AW-1:0]       ROW_STEP = AW'(1 << COL_BITS);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_C, S_RD_N, S_RD_W, S_RD_E, S_RD_S, S_EVAL, S_WRITE, S_DONE
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       pix_q;
    logic [DW-1:0]       c_q, n_q, w_q, e_q;
    logic [15:0]         word_q;
    logic                res_rd_q;
    logic [AW-1:0]       res_addr_q;
    logic                sk_wr_q;
    logic [AW-5:0]       sk_addr_q;
    logic [15:0]         sk_do_q;
    logic [DW-1:0]       max_q;
    logic [AW:0]         cnt_q;
    logic                busy_q, done_q;

    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic                top_row, bot_row, left_col, right_col;
    logic [DW-1:0]       s_val;
    logic                flag;
    logic [15:0]         word_d;

    assign row       = pix_q[AW-1:COL_BITS];
    assign col       = pix_q[COL_BITS-1:0];
    assign top_row   = (row == '0);
    assign bot_row   = (row == ROW_MAX);
    assign left_col  = (col == '0);
    assign right_col = (col == COL_MAX);

    // South value arrives in EVAL itself, so it is used straight off the RAM port.
    assign s_val  = bot_row ? '0 : res_di_i;
    assign flag   = (c_q != '0) && (c_q >= n_q) && (c_q >= w_q) && (c_q >= e_q) && (c_q >= s_val);
    assign word_d = word_q | (16'(flag) << (4'd15 - col[3:0]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pix_q      <= '0;
            c_q        <= '0;
            n_q        <= '0;
            w_q        <= '0;
            e_q        <= '0;
            word_q     <= '0;
            res_rd_q   <= 1'b0;
            res_addr_q <= '0;
            sk_wr_q    <= 1'b0;
            sk_addr_q  <= '0;
            sk_do_q    <= '0;
            max_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sk_wr_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q    <= S_RD_C;
                        pix_q      <= '0;
                        word_q     <= '0;
                        res_rd_q   <= 1'b1;
                        res_addr_q <= '0;
                        max_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                // Address for the next read is registered one state ahead of its slot.
                S_RD_C: begin
                    state_q    <= S_RD_N;
                    res_addr_q <= top_row ? pix_q : pix_q - ROW_STEP;
                end
                S_RD_N: begin
                    c_q        <= res_di_i;
                    state_q    <= S_RD_W;
                    res_addr_q <= left_col ? pix_q : pix_q - 1'b1;
                end
                S_RD_W: begin
                    n_q        <= top_row ? '0 : res_di_i;
                    state_q    <= S_RD_E;
                    res_addr_q <= right_col ? pix_q : pix_q + 1'b1;
                end
                S_RD_E: begin
                    w_q        <= left_col ? '0 : res_di_i;
                    state_q    <= S_RD_S;
                    res_addr_q <= bot_row ? pix_q : pix_q + ROW_STEP;
                end
                S_RD_S: begin
                    e_q      <= right_col ? '0 : res_di_i;
                    state_q  <= S_EVAL;
                    res_rd_q <= 1'b0;
                end
                S_EVAL: begin
                    cnt_q <= cnt_q + {{AW{1'b0}}, flag};
                    if (c_q > max_q)
                        max_q <= c_q;
                    if (col[3:0] == 4'hF) begin
                        state_q   <= S_WRITE;
                        sk_wr_q   <= 1'b1;
                        sk_addr_q <= pix_q[AW-1:4];
                        sk_do_q   <= word_d;
                        word_q    <= '0;
                    end else begin
                        state_q    <= S_RD_C;
                        word_q     <= word_d;
                        pix_q      <= pix_q + 1'b1;
                        res_rd_q   <= 1'b1;
                        res_addr_q <= pix_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    pix_q <= pix_q + 1'b1;
                    if (pix_q == '1) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_RD_C;
                        res_rd_q   <= 1'b1;
                        res_addr_q <= pix_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign res_rd_o   = res_rd_q;
    assign res_addr_o = res_addr_q;
    assign sk_wr_o    = sk_wr_q;
    assign sk_addr_o  = sk_addr_q;
    assign sk_do_o    = sk_do_q;
    assign max_dist_o = max_q;
    assign sk_count_o = cnt_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_dt_skeleton_extract.sv
// Bench for dt_skeleton_extract on a reduced 16x32 image so that many full scans fit
// in a short run; a direct local-maximum model supplies every expected word.
module tb_dt_skeleton_extract;

    localparam int RB     = 4;
    localparam int CB     = 5;
    localparam int ROWS   = 1 << RB;
    localparam int COLS   = 1 << CB;
    localparam int NPIX   = ROWS * COLS;
    localparam int WPR    = COLS / 16;
    localparam int NWORDS = NPIX / 16;
    localparam int LAT    = NPIX * 6 + NWORDS;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              res_rd;
    logic [RB+CB-1:0]  res_addr;
    logic [7:0]        res_di = '0;
    logic              sk_wr;
    logic [RB+CB-5:0]  sk_addr;
    logic [15:0]       sk_do;
    logic [7:0]        max_dist;
    logic [RB+CB:0]    sk_count;
    logic              busy;
    logic              done;

    dt_skeleton_extract #(.ROW_BITS(RB), .COL_BITS(CB), .DW(8)) dut (
        .clk(clk), .reset(reset), .start_i(start),
        .res_rd_o(res_rd), .res_addr_o(res_addr), .res_di_i(res_di),
        .sk_wr_o(sk_wr), .sk_addr_o(sk_addr), .sk_do_o(sk_do),
        .max_dist_o(max_dist), .sk_count_o(sk_count),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [NPIX];
    logic [15:0] exp_words [NWORDS];
    int          exp_count;
    int          exp_max;
    int          wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic        mon_en = 1'b0;

    // Distance RAM: one-cycle registered read.
    always @(posedge clk)
        if (res_rd) res_di <= mem[res_addr];

    always @(negedge clk)
        if (mon_en && sk_wr) begin
            wr_addr_q.push_back(int'(sk_addr));
            wr_data_q.push_back(sk_do);
        end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int px(input int r, input int c);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 0;
        return int'(mem[r*COLS + c]);
    endfunction

    task automatic build_model();
        int v;
        foreach (exp_words[i]) exp_words[i] = '0;
        exp_count = 0;
        exp_max   = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                v = px(r, c);
                if (v > exp_max) exp_max = v;
                if (v > 0 && v >= px(r-1, c) && v >= px(r+1, c) && v >= px(r, c-1) && v >= px(r, c+1)) begin
                    exp_words[r*WPR + c/16][15 - (c % 16)] = 1'b1;
                    exp_count++;
                end
            end
    endtask

    task automatic clear_map();
        foreach (mem[i]) mem[i] = '0;
    endtask

    task automatic set_px(input int r, input int c, input int v);
        mem[r*COLS + c] = 8'(v);
    endtask

    task automatic run_scan(input string name, input int restart_at);
        int cyc;
        build_model();
        wr_addr_q.delete();
        wr_data_q.delete();
        mon_en = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({name, " busy_after_start"}, busy, 1);
        check({name, " done_after_start"}, done, 0);
        cyc = 0;
        while (!done && cyc < LAT + 50) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
        end
        start = 1'b0;
        check({name, " latency"}, cyc, LAT);
        check({name, " busy_at_done"}, busy, 0);
        repeat (3) @(negedge clk);
        check({name, " done_held"}, done, 1);
        mon_en = 1'b0;
        check({name, " write_count"}, wr_addr_q.size(), NWORDS);
        for (int i = 0; i < NWORDS && i < wr_addr_q.size(); i++) begin
            check({name, " word_addr"}, wr_addr_q[i], i);
            check({name, " word_data"}, wr_data_q[i], exp_words[i]);
        end
        check({name, " sk_count"}, sk_count, exp_count);
        check({name, " max_dist"}, max_dist, exp_max);
        $display("scan %s: writes=%0d sk_count=%0d max_dist=%0d cycles=%0d",
                 name, wr_addr_q.size(), sk_count, max_dist, cyc);
    endtask

    typedef struct {
        string name;
        int    kind;        // 0 zero map, 1 single pixel, 2 3x3 block, 3 horizontal pair
        int    r;
        int    c;
        int    v;
        int    exp_count;
        int    exp_max;
        int    word_addr;
        int    word_val;
    } vec_t;

    vec_t vecs [7];

    task automatic load_vec(input vec_t t);
        clear_map();
        case (t.kind)
            1: set_px(t.r, t.c, t.v);
            2: begin
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        set_px(t.r + dr, t.c + dc, t.v - 1);
                set_px(t.r, t.c, t.v);
            end
            3: begin
                set_px(t.r, t.c, t.v);
                set_px(t.r, t.c + 1, t.v);
            end
            default: ;
        endcase
    endtask

    initial begin
        int wr_in_reset;
        vecs[0] = '{"zero",      0, 0,  0,   0, 0,   0,  0, 16'h0000};
        vecs[1] = '{"single",    1, 5,  5,   1, 1,   1, 10, 16'h0400};
        vecs[2] = '{"block",     2, 10, 10,  2, 5,   2, 20, 16'h0020};
        vecs[3] = '{"corner_tr", 1, 0,  31,  3, 1,   3,  1, 16'h0001};
        vecs[4] = '{"corner_bl", 1, 15, 0, 200, 1, 200, 30, 16'h8000};
        vecs[5] = '{"corner_br", 1, 15, 31, 255, 1, 255, 31, 16'h0001};
        vecs[6] = '{"plateau",   3, 3,  3,   7, 2,   7,  6, 16'h1800};

        reset = 1'b0;
        start = 1'b0;
        clear_map();
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, sk_wr, res_rd, res_addr, sk_addr, sk_do, max_dist, sk_count}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[k]) begin
            load_vec(vecs[k]);
            run_scan(vecs[k].name, -1);
            check({vecs[k].name, " tbl_count"}, sk_count, vecs[k].exp_count);
            check({vecs[k].name, " tbl_max"}, max_dist, vecs[k].exp_max);
            if (vecs[k].word_addr < wr_data_q.size())
                check({vecs[k].name, " tbl_word"}, wr_data_q[vecs[k].word_addr], vecs[k].word_val);
            else
                check({vecs[k].name, " tbl_word_missing"}, wr_data_q.size(), vecs[k].word_addr + 1);
        end

        // Second start mid-scan must be ignored; a start after done reruns cleanly.
        load_vec(vecs[2]);
        run_scan("restart_ignored", 1000);
        check("restart_word18", (wr_data_q.size() > 18) ? wr_data_q[18] : 16'hdead, 16'h0050);
        run_scan("rerun_after_done", -1);

        for (int n = 0; n < 3; n++) begin
            foreach (mem[i]) mem[i] = (n == 2) ? ((($urandom % 8) == 0) ? 8'($urandom) : 8'd0)
                                               : 8'($urandom_range(0, 3));
            run_scan($sformatf("random%0d", n), -1);
        end

        // Asynchronous reset in the middle of a scan.
        foreach (mem[i]) mem[i] = 8'($urandom_range(1, 9));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (1500) @(negedge clk);
        check("midscan_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("midscan_reset_outputs",
              {busy, done, sk_wr, res_rd, res_addr, sk_addr, sk_do, max_dist, sk_count}, 0);
        wr_in_reset = 0;
        repeat (5) begin
            @(negedge clk);
            if (sk_wr) wr_in_reset++;
        end
        check("midscan_no_writes", wr_in_reset, 0);
        $display("reset mid-scan: writes_while_reset=%0d busy=%0d done=%0d", wr_in_reset, busy, done);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        run_scan("after_reset", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
